// File: rtl/x_delay_line_measure.sv
// Delay-line tap measurement: decodes each captured thermometer snapshot to an edge
// position and reports sum/min/max/bubble over 2**LOG2_SAMPLES samples.
module x_delay_line_measure #(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 6,
  parameter int LOG2_SAMPLES = 4,
  parameter int SUM_W        = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [SUM_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_min,
  output logic [CNT_W-1:0] o_max,
  output logic             o_err
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACC, DONE} state_t;

  state_t                  state;
  logic [WIDTH-1:0]        data_p0;
  logic [CNT_W-1:0]        pos_p0;
  logic                    bubble_p0;
  logic                    seen_p0;
  logic [1:0]              scnt;
  logic [LOG2_SAMPLES-1:0] acnt;

  // Stage p0: tap capture, free-running regardless of state
  always_ff @(posedge i_clk) begin
    data_p0 <= i_data;
  end

  // Polarity follows bit 0 because the launch flop toggles every cycle
  always_comb begin
    pos_p0    = CNT_W'(WIDTH);
    bubble_p0 = 1'b0;
    seen_p0   = 1'b0;
    for (int j = 1; j < WIDTH; j++) begin
      if (data_p0[j] != data_p0[0]) begin
        if (!seen_p0) pos_p0 = CNT_W'(j);
        seen_p0 = 1'b1;
      end else if (seen_p0) begin
        bubble_p0 = 1'b1;
      end
    end
  end

  // Stage p1: measurement control and accumulation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      scnt    <= '0;
      acnt    <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_sum   <= '0;
      o_min   <= '0;
      o_max   <= '0;
      o_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= SETTLE;
            scnt   <= 2'd1;
            o_busy <= 1'b1;
            o_sum  <= '0;
            o_min  <= CNT_W'(WIDTH);
            o_max  <= '0;
            o_err  <= 1'b0;
          end
        end
        SETTLE: begin
          if (scnt == 2'd2) begin
            state <= ACC;
            acnt  <= '0;
          end else begin
            scnt <= scnt + 2'd1;
          end
        end
        ACC: begin
          o_sum <= o_sum + SUM_W'(pos_p0);
          if (pos_p0 < o_min) o_min <= pos_p0;
          if (pos_p0 > o_max) o_max <= pos_p0;
          o_err <= o_err | bubble_p0;
          acnt  <= acnt + 1'b1;
          if (acnt == '1) begin
            state   <= DONE;
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_delay_line_measure.sv
// Bench for x_delay_line_measure: directed table of tap patterns plus randomized
// measurements checked against an arithmetic reference model.
module tb_x_delay_line_measure;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int LOG2_SAMPLES = 4;
  localparam int SUM_W = 10;
  localparam int M = 1 << LOG2_SAMPLES;

  logic             clk = 1'b0;
  logic             i_rst, i_start, i_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_busy, o_valid, o_err;
  logic [SUM_W-1:0] o_sum;
  logic [CNT_W-1:0] o_min, o_max;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH-1:0] stim [M];

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    int          esum;
    int          emin;
    int          emax;
    int          eerr;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  x_delay_line_measure #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .LOG2_SAMPLES(LOG2_SAMPLES), .SUM_W(SUM_W)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_data(i_data),
    .i_ready(i_ready), .o_busy(o_busy), .o_valid(o_valid), .o_sum(o_sum),
    .o_min(o_min), .o_max(o_max), .o_err(o_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Edge position: index of the lowest bit that differs from bit 0
  function automatic int model_pos(input logic [31:0] w);
    logic [31:0] x;
    x = w ^ {32{w[0]}};
    if (x == 32'd0) return 32;
    return $countones((x & (~x + 32'd1)) - 32'd1);
  endfunction

  // Bubble: above the edge, every bit must differ from bit 0
  function automatic int model_bub(input logic [31:0] w);
    logic [31:0] x;
    int p;
    x = w ^ {32{w[0]}};
    p = model_pos(w);
    if (p == 32) return 0;
    return ((x | ((32'd1 << p) - 32'd1)) != 32'hFFFF_FFFF) ? 1 : 0;
  endfunction

  function automatic logic [31:0] therm(input int p, input logic r);
    logic [31:0] mask;
    mask = (p >= 32) ? 32'd0 : (32'hFFFF_FFFF << p);
    return r ? ~mask : mask;
  endfunction

  // Runs one measurement with stim[] and checks latency and results against the model
  task automatic run_meas(input string tag);
    int s, mn, mx, e;
    s = 0; mn = WIDTH; mx = 0; e = 0;
    for (int i = 0; i < M; i++) begin
      s += model_pos(stim[i]);
      if (model_pos(stim[i]) < mn) mn = model_pos(stim[i]);
      if (model_pos(stim[i]) > mx) mx = model_pos(stim[i]);
      e |= model_bub(stim[i]);
    end
    i_start = 1'b1;
    i_data  = stim[0];
    tick();
    i_start = 1'b0;
    chk({tag, " busy"}, 32'(o_busy), 32'd1);
    tick();
    for (int i = 0; i < M; i++) begin
      i_data = stim[i];
      tick();
    end
    chk({tag, " early_valid"}, 32'(o_valid), 32'd0);
    tick();
    i_data = $urandom;
    chk({tag, " valid"}, 32'(o_valid), 32'd1);
    chk({tag, " sum"}, 32'(o_sum), 32'(s));
    chk({tag, " min"}, 32'(o_min), 32'(mn));
    chk({tag, " max"}, 32'(o_max), 32'(mx));
    chk({tag, " err"}, 32'(o_err), 32'(e));
  endtask

  task automatic accept(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, " acc_valid"}, 32'(o_valid), 32'd0);
    chk({tag, " acc_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    logic [SUM_W-1:0] hs;
    logic [CNT_W-1:0] hmn, hmx;
    logic             he;
    int               p;

    tbl[0] = '{"const_ff",  32'h0000_00FF, 32'h0000_00FF, 128,  8,  8, 0};
    tbl[1] = '{"alt_pol",   32'h0000_0FFF, 32'hFFFF_F000, 192, 12, 12, 0};
    tbl[2] = '{"bubble_f7", 32'h0000_00F7, 32'h0000_00F7,  48,  3,  3, 1};
    tbl[3] = '{"all_ones",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 512, 32, 32, 0};
    tbl[4] = '{"mix_4_20",  32'h0000_000F, 32'h000F_FFFF, 192,  4, 20, 0};
    tbl[5] = '{"alt_bits",  32'hAAAA_AAAA, 32'hAAAA_AAAA,  16,  1,  1, 1};

    i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b0; i_data = '0;
    tick(); tick();
    i_rst = 1'b0;
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset valid", 32'(o_valid), 32'd0);
    chk("reset sum", 32'(o_sum), 32'd0);
    chk("reset min", 32'(o_min), 32'd0);
    chk("reset max", 32'(o_max), 32'd0);
    chk("reset err", 32'(o_err), 32'd0);

    // Directed table: even samples a, odd samples b
    foreach (tbl[t]) begin
      for (int i = 0; i < M; i++) stim[i] = (i % 2 == 0) ? tbl[t].a : tbl[t].b;
      run_meas(tbl[t].name);
      chk({tbl[t].name, " tbl_sum"}, 32'(o_sum), 32'(tbl[t].esum));
      chk({tbl[t].name, " tbl_min"}, 32'(o_min), 32'(tbl[t].emin));
      chk({tbl[t].name, " tbl_max"}, 32'(o_max), 32'(tbl[t].emax));
      chk({tbl[t].name, " tbl_err"}, 32'(o_err), 32'(tbl[t].eerr));
      accept(tbl[t].name);
    end

    // Reset mid-accumulation discards the partial result
    for (int i = 0; i < M; i++) stim[i] = 32'h0000_00F7;
    i_start = 1'b1; i_data = stim[0];
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    chk("midrst busy", 32'(o_busy), 32'd0);
    chk("midrst valid", 32'(o_valid), 32'd0);
    chk("midrst sum", 32'(o_sum), 32'd0);
    chk("midrst min", 32'(o_min), 32'd0);
    chk("midrst max", 32'(o_max), 32'd0);
    chk("midrst err", 32'(o_err), 32'd0);
    tick();
    chk("midrst idle", 32'(o_busy), 32'd0);

    // Backpressure in DONE: results hold and i_start is ignored
    for (int i = 0; i < M; i++) stim[i] = (i < 8) ? 32'h0000_000F : 32'hFFF0_0000;
    run_meas("hold");
    hs = o_sum; hmn = o_min; hmx = o_max; he = o_err;
    for (int c = 0; c < 10; c++) begin
      i_start = (c == 4);
      i_data  = $urandom;
      tick();
      chk("hold valid", 32'(o_valid), 32'd1);
      chk("hold sum", 32'(o_sum), 32'(hs));
      chk("hold min", 32'(o_min), 32'(hmn));
      chk("hold max", 32'(o_max), 32'(hmx));
      chk("hold err", 32'(o_err), 32'(he));
    end
    i_start = 1'b1;
    accept("hold");
    i_start = 1'b0;
    tick();
    chk("start_on_accept ignored", 32'(o_busy), 32'd0);
    chk("idle keeps sum", 32'(o_sum), 32'(hs));

    // Randomized measurements against the reference model
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < M; i++) begin
        p = $urandom_range(1, 32);
        stim[i] = therm(p, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) stim[i][$urandom_range(0, 31)] ^= 1'b1;
        if ($urandom_range(0, 7) == 0) stim[i] = $urandom;
      end
      run_meas("rand");
      for (int w = $urandom_range(0, 3); w > 0; w--) begin
        tick();
        chk("rand wait valid", 32'(o_valid), 32'd1);
      end
      accept("rand");
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
